// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between pipeline writeback and queued LLU results,
// forcing a one-cycle MEM/WB stall when a queued LLU result has been blocked for STARVE_LIMIT cycles.
module wb_port_arbiter #(
    parameter int XLEN         = 32,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pipe_we_i,
    input  logic [4:0]               pipe_rd_i,
    input  logic [XLEN-1:0]          pipe_data_i,
    input  logic                     llu_valid_i,
    output logic                     llu_ready_o,
    input  logic [4:0]               llu_rd_i,
    input  logic [XLEN-1:0]          llu_data_i,
    output logic                     stall_o,
    output logic                     rf_we_o,
    output logic [4:0]               rf_waddr_o,
    output logic [XLEN-1:0]          rf_wdata_o,
    output logic                     llu_pending_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] FULL  = CW'(DEPTH);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    logic [4:0]      q_rd   [DEPTH];
    logic [XLEN-1:0] q_data [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic [SW-1:0]   starve_cnt;
    logic            empty, pipe_req, forced, pop, push;

    always_comb begin
        empty    = count == '0;
        pipe_req = pipe_we_i && pipe_rd_i != 5'd0;
        forced   = pipe_req && !empty && starve_cnt == LIMIT;
        pop      = !empty && (forced || !pipe_req);
        push     = llu_valid_i && llu_ready_o;
    end

    // A full FIFO refuses a push even when it pops that cycle, keeping ready off the pop path.
    assign llu_ready_o   = count != FULL;
    assign llu_pending_o = !empty;
    assign count_o       = count;
    assign stall_o       = forced;
    assign rf_we_o       = pop ? q_rd[rd_ptr] != 5'd0 : pipe_req;
    assign rf_waddr_o    = pop ? q_rd[rd_ptr] : pipe_rd_i;
    assign rf_wdata_o    = pop ? q_data[rd_ptr] : pipe_data_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (push != pop) count <= push ? count + CW'(1) : count - CW'(1);
            starve_cnt <= (empty || pop) ? '0 : (starve_cnt == LIMIT ? LIMIT : starve_cnt + SW'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_rd[wr_ptr]   <= llu_rd_i;
            q_data[wr_ptr] <= llu_data_i;
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed and random stimulus checked against a queue-based model of the
// writeback arbitration rules.
module tb_wb_port_arbiter;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_we, llu_valid, llu_ready, stall, rf_we, llu_pending;
    logic [4:0]  pipe_rd, llu_rd, rf_waddr;
    logic [31:0] pipe_data, llu_data, rf_wdata;
    logic [1:0]  count;

    logic [4:0]  mq_rd[$];
    logic [31:0] mq_data[$];
    int          starve;
    int          vectors = 0;
    int          miscompares = 0;

    wb_port_arbiter #(.XLEN(32), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .pipe_we_i(pipe_we), .pipe_rd_i(pipe_rd), .pipe_data_i(pipe_data),
        .llu_valid_i(llu_valid), .llu_ready_o(llu_ready), .llu_rd_i(llu_rd), .llu_data_i(llu_data),
        .stall_o(stall), .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
        .llu_pending_o(llu_pending), .count_o(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] rd, input logic [31:0] d,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
        pipe_we = we; pipe_rd = rd; pipe_data = d;
        llu_valid = lv; llu_rd = lrd; llu_data = ld;
    endtask

    // Model: the LLU queue writes when the pipe is silent or the head has starved for LIMIT cycles.
    task automatic chk();
        bit preq, take;
        #1;
        preq = pipe_we && pipe_rd != 5'd0;
        take = mq_rd.size() > 0 && (!preq || starve == LIMIT);
        check("stall", stall, preq && take);
        check("rf_we", rf_we, take ? mq_rd[0] != 5'd0 : preq);
        check("waddr", rf_waddr, take ? mq_rd[0] : pipe_rd);
        check("wdata", rf_wdata, take ? mq_data[0] : pipe_data);
        check("ready", llu_ready, mq_rd.size() < DEPTH);
        check("pending", llu_pending, mq_rd.size() > 0);
        check("count", count, mq_rd.size());
    endtask

    task automatic tick();
        bit preq, take, was_empty, can_push;
        @(posedge clk);
        preq      = pipe_we && pipe_rd != 5'd0;
        was_empty = mq_rd.size() == 0;
        can_push  = mq_rd.size() < DEPTH;
        take      = !was_empty && (!preq || starve == LIMIT);
        if (take) begin
            void'(mq_rd.pop_front());
            void'(mq_data.pop_front());
        end
        if (llu_valid && can_push) begin
            mq_rd.push_back(llu_rd);
            mq_data.push_back(llu_data);
        end
        starve = (was_empty || take) ? 0 : (starve < LIMIT ? starve + 1 : LIMIT);
        @(negedge clk);
    endtask

    task automatic mid_reset();
        rst = 1'b0;
        mq_rd.delete();
        mq_data.delete();
        starve = 0;
        chk();
        check("rst_count", count, 0);
        check("rst_ready", llu_ready, 1);
        check("rst_stall", stall, 0);
        check("rst_pending", llu_pending, 0);
        #2 rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        chk();
        tick();
    endtask

    initial begin
        rst = 1'b0;
        starve = 0;
        drive(0, 0, 0, 0, 0, 0);
        chk();
        @(negedge clk);
        rst = 1'b1;
        // Idle pipe: a pushed result writes the following cycle.
        drive(0, 0, 0, 1, 5, 32'hDEADBEEF); chk(); tick();
        drive(0, 0, 0, 0, 0, 0); chk();
        check("t2_we", rf_we, 1);
        check("t2_addr", rf_waddr, 5);
        check("t2_data", rf_wdata, 32'hDEADBEEF);
        tick();
        chk();
        // Busy pipe starves the head until a forced single-cycle stall.
        drive(1, 3, 32'h33, 1, 7, 32'h77); chk(); tick();
        for (int i = 1; i <= 6; i++) begin
            drive(1, 3, 32'h33, 0, 0, 0); chk();
            if (i == 5) begin
                check("t3_stall", stall, 1);
                check("t3_addr7", rf_waddr, 7);
            end
            if (i == 6) begin
                check("t3_nostall", stall, 0);
                check("t3_addr3", rf_waddr, 3);
            end
            tick();
        end
        // x0 pipe write is not a request; x0 LLU result pops silently.
        drive(1, 3, 32'h33, 1, 9, 32'h99); chk(); tick();
        drive(1, 0, 32'h55, 0, 0, 0); chk();
        check("t5_addr9", rf_waddr, 9);
        check("t5_we", rf_we, 1);
        tick();
        drive(1, 3, 32'h33, 1, 0, 32'hAA); chk(); tick();
        drive(0, 0, 0, 0, 0, 0); chk();
        check("t5_x0_we", rf_we, 0);
        tick();
        chk();
        // Simultaneous push and pop keep the count.
        drive(1, 3, 32'h33, 1, 11, 32'hB); chk(); tick();
        drive(0, 0, 0, 1, 12, 32'hA); chk();
        check("t6_addrB", rf_waddr, 11);
        tick();
        drive(0, 0, 0, 0, 0, 0); chk();
        check("t6_count", count, 1);
        check("t6_addrA", rf_waddr, 12);
        tick();
        // Back-to-back offers against a busy pipe fill the FIFO.
        drive(1, 3, 32'h33, 1, 20, 32'h20); chk(); tick();
        drive(1, 3, 32'h33, 1, 21, 32'h21); chk(); tick();
        drive(1, 3, 32'h33, 1, 22, 32'h22); chk();
        check("t4_ready", llu_ready, 0);
        check("t4_count", count, 2);
        tick();
        chk();
        mid_reset();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
            chk();
            if (i == 200) mid_reset();
            else tick();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
